tm1638_key_reader: RTL and testbench

//  Periodic key-scan reader for the TM1638; the read-side peer of the display driver.

---
 rtl/tm1638_key_reader_pkg.sv | 18 +
 rtl/tm1638_key_decode.sv | 20 ++
 rtl/tm1638_key_reader.sv | 161 ++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_key_reader_pkg.sv
// Shared types and constants for the TM1638 key-scan reader.
package tm1638_key_reader_pkg;

    typedef logic [2:0][7:0] keys_t;

    localparam logic [7:0]  CMD_READ_KEYS = 8'h42;
    localparam int unsigned KEY_BYTES     = 4;
    localparam logic [2:0]  KEY_RD_LEN    = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_RX,
        DECODE,
        PUBLISH
    } key_state_t;

endpackage

// File: rtl/tm1638_key_decode.sv
// Maps the four TM1638 key-scan bytes onto the 3 K-line x 8 SEG key map.
module tm1638_key_decode
    import tm1638_key_reader_pkg::*;
(
    input  logic [KEY_BYTES-1:0][7:0] rx_bytes,
    output keys_t                     keys
);

    // Byte b carries SEG 2b in bits 0..2 and SEG 2b+1 in bits 4..6, ordered K3,K2,K1.
    always_comb begin
        keys = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            for (int k = 0; k < 3; k++) begin
                keys[k][2*b]   = rx_bytes[b][2-k];
                keys[k][2*b+1] = rx_bytes[b][6-k];
            end
        end
    end

endmodule

// File: rtl/tm1638_key_reader.sv
// Periodic TM1638 key scan through the shared SPI command FIFO, state updates on falling edge.
// Define TM1638_KEY_DEBOUNCE_EN to publish only maps seen DEBOUNCE_SCANS times in a row.
module tm1638_key_reader
    import tm1638_key_reader_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD    = 1_000_000,
    parameter int unsigned RX_TIMEOUT     = 4096,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic       i_SPI_FIFO_Full,
    output logic [7:0] o_Cmd_Data,
    output logic [2:0] o_Cmd_Rd_Len,
    output logic       o_Cmd_Write,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Rx_Valid,
    output keys_t      o_Keys,
    output logic       o_Keys_Valid,
    output logic       o_Keys_Changed,
    output logic       o_Rx_Error
);

    localparam int unsigned      TMR_W     = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int unsigned      TMO_W     = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SCAN_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RX_TIMEOUT - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(KEY_BYTES - 1);

    key_state_t                state_q;
    logic [TMR_W-1:0]          timer_q;
    logic                      scan_due_q;
    logic [TMO_W-1:0]          tmo_q;
    logic [1:0]                cnt_q;
    logic [KEY_BYTES-1:0][7:0] bytes_q;
    keys_t                     dec_keys;
    keys_t                     dec_q;
    logic                      wrap;
    logic                      due;
    logic                      publish;

    assign wrap = (timer_q == TMR_LAST);
    assign due  = scan_due_q | wrap;

    tm1638_key_decode u_decode (
        .rx_bytes (bytes_q),
        .keys     (dec_keys)
    );

`ifdef TM1638_KEY_DEBOUNCE_EN
    localparam int unsigned     DB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DB_W-1:0] DB_CNT = DB_W'(DEBOUNCE_SCANS);

    keys_t           cand_q;
    logic [DB_W-1:0] match_q;
    logic [DB_W-1:0] match_d;
    logic            same;

    // Publish only on the scan that first brings the run length up to DB_CNT.
    always_comb begin
        same    = (dec_q == cand_q);
        match_d = DB_W'(1);
        if (same) begin
            match_d = (match_q == DB_CNT) ? match_q : match_q + 1'b1;
        end
        publish = (match_d == DB_CNT) && !(same && (match_q == DB_CNT));
    end
`else
    assign publish = 1'b1;
`endif

    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            scan_due_q     <= 1'b0;
            tmo_q          <= '0;
            cnt_q          <= '0;
            bytes_q        <= '0;
            dec_q          <= '0;
            o_Cmd_Data     <= '0;
            o_Cmd_Rd_Len   <= '0;
            o_Cmd_Write    <= 1'b0;
            o_Keys         <= '0;
            o_Keys_Valid   <= 1'b0;
            o_Keys_Changed <= 1'b0;
            o_Rx_Error     <= 1'b0;
`ifdef TM1638_KEY_DEBOUNCE_EN
            cand_q         <= '0;
            match_q        <= '0;
`endif
        end else begin
            timer_q        <= wrap ? '0 : timer_q + 1'b1;
            scan_due_q     <= due;
            o_Cmd_Write    <= 1'b0;
            o_Keys_Valid   <= 1'b0;
            o_Keys_Changed <= 1'b0;
            o_Rx_Error     <= 1'b0;
            if (i_Rx_Valid && (state_q != WAIT_RX)) begin
                o_Rx_Error <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (due && i_Enable) begin
                        scan_due_q <= 1'b0;
                        state_q    <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (!i_SPI_FIFO_Full) begin
                        o_Cmd_Write  <= 1'b1;
                        o_Cmd_Data   <= CMD_READ_KEYS;
                        o_Cmd_Rd_Len <= KEY_RD_LEN;
                        tmo_q        <= '0;
                        cnt_q        <= '0;
                        state_q      <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    // A byte arriving on the expiry cycle wins; the counter parks at its limit.
                    if (i_Rx_Valid) begin
                        bytes_q[cnt_q] <= i_Rx_Byte;
                        cnt_q          <= cnt_q + 1'b1;
                        if (tmo_q != TMO_LAST) begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                        if (cnt_q == LAST_BYTE) begin
                            state_q <= DECODE;
                        end
                    end else if ((RX_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                        o_Rx_Error <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DECODE: begin
                    dec_q   <= dec_keys;
                    state_q <= PUBLISH;
                end
                PUBLISH: begin
`ifdef TM1638_KEY_DEBOUNCE_EN
                    cand_q  <= dec_q;
                    match_q <= match_d;
`endif
                    if (publish) begin
                        o_Keys         <= dec_q;
                        o_Keys_Valid   <= 1'b1;
                        o_Keys_Changed <= (dec_q != o_Keys);
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader with a scan-level model checked every cycle.
module tb_tm1638_key_reader;

    localparam int NONE = -1000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fifo_full;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  cmd_data;
    logic [2:0]  rd_len;
    logic        cmd_write;
    logic [23:0] keys;
    logic        keys_valid;
    logic        keys_changed;
    logic        rx_error;

    int          cyc = -1;
    int          n_pass = 0;
    int          n_chk = 0;
    int          exp_write = NONE;
    int          exp_valid = NONE;
    int          exp_err = NONE;
    logic        exp_changed = 1'b0;
    logic [23:0] next_keys = '0;
    logic [23:0] cur_keys = '0;
    logic [23:0] last_pub = '0;
    logic [23:0] run_map = '0;
    int          run_len = 0;

    tm1638_key_reader #(
        .SCAN_PERIOD    (32),
        .RX_TIMEOUT     (64),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Enable        (enable),
        .i_SPI_FIFO_Full (fifo_full),
        .o_Cmd_Data      (cmd_data),
        .o_Cmd_Rd_Len    (rd_len),
        .o_Cmd_Write     (cmd_write),
        .i_Rx_Byte       (rx_byte),
        .i_Rx_Valid      (rx_valid),
        .o_Keys          (keys),
        .o_Keys_Valid    (keys_valid),
        .o_Keys_Changed  (keys_changed),
        .o_Rx_Error      (rx_error)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Cycle index: 0 is the first falling edge with reset released.
    always @(negedge clk) cyc <= rst ? -1 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    endtask

    // Key (kline k, seg s) lives in byte s/2, bit 4*(s%2) + (2-k).
    function automatic logic [23:0] model_decode(input logic [31:0] bs);
        logic [23:0] m;
        m = '0;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < 8; s++)
                m[k*8+s] = bs[8*(s/2) + 4*(s%2) + 2 - k];
        return m;
    endfunction

    task automatic expect_scan(input int r, input logic [31:0] bs);
        logic [23:0] m;
        bit          fire;
        m = model_decode(bs);
        if (m == run_map) run_len++;
        else begin
            run_map = m;
            run_len = 1;
        end
`ifdef TM1638_KEY_DEBOUNCE_EN
        fire = (run_len == 3);
`else
        fire = 1'b1;
`endif
        if (fire) begin
            exp_valid   = r + 2;
            next_keys   = m;
            exp_changed = (m != last_pub);
            last_pub    = m;
        end
    endtask

    always @(posedge clk) begin
        if (cyc < 0) begin
            cur_keys = '0;
            chk("reset_cmd_data", 32'(cmd_data), 32'h0);
            chk("reset_rd_len", 32'(rd_len), 32'h0);
        end
        if (cyc == exp_valid) cur_keys = next_keys;
        chk("keys", 32'(keys), 32'(cur_keys));
        chk("keys_valid", 32'(keys_valid), 32'(cyc == exp_valid));
        if (cyc == exp_valid) chk("keys_changed", 32'(keys_changed), 32'(exp_changed));
        chk("cmd_write", 32'(cmd_write), 32'(cyc == exp_write));
        if (cyc == exp_write) begin
            chk("cmd_data", 32'(cmd_data), 32'h42);
            chk("cmd_rd_len", 32'(rd_len), 32'h4);
        end
        chk("rx_error", 32'(rx_error), 32'(cyc == exp_err));
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic int next_wrap(input int c);
        return c + ((31 - (c % 32)) + 32) % 32;
    endfunction

    task automatic send_bytes(input logic [31:0] bs, input int n, output int r);
        for (int j = 0; j < n; j++) begin
            rx_byte  = bs[8*j +: 8];
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        r        = cyc;
    endtask

    // Enable for one cycle right after a timer wrap: command write lands two cycles later.
    task automatic scan(input logic [31:0] bs, input int n, output int r);
        int w;
        w = next_wrap(cyc);
        wait_until(w);
        enable    = 1'b1;
        exp_write = w + 2;
        tick();
        enable = 1'b0;
        wait_until(w + 2);
        send_bytes(bs, n, r);
        if (n == 4) expect_scan(r, bs);
    endtask

    initial begin
        int r;
        int w;
        rst       = 1'b1;
        enable    = 1'b1;
        fifo_full = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = '0;
        tick();
        tick();
        tick();
        chk("t0_keys", 32'(keys), 32'h0);
        chk("t0_write", 32'(cmd_write), 32'h0);

        // First scan from reset.
        exp_write = 32;
        rst       = 1'b0;
        wait_until(32);
        chk("t1_write", 32'(cmd_write), 32'h1);
        chk("t1_data", 32'(cmd_data), 32'h42);
        chk("t1_len", 32'(rd_len), 32'h4);
        enable = 1'b0;
        send_bytes(32'h40041001, 4, r);
        expect_scan(r, 32'h40041001);
        chk("t2_byte4_cycle", r, 36);
        wait_until(r + 2);
`ifndef TM1638_KEY_DEBOUNCE_EN
        chk("t2_keys", 32'(keys), 32'h090090);
        chk("t2_valid", 32'(keys_valid), 32'h1);
        chk("t2_changed", 32'(keys_changed), 32'h1);
`endif

        // FIFO full for the first 10 cycles of the scan.
        w = next_wrap(cyc);
        wait_until(w);
        fifo_full = 1'b1;
        enable    = 1'b1;
        tick();
        enable = 1'b0;
        repeat (9) tick();
        fifo_full = 1'b0;
        exp_write = w + 11;
        wait_until(w + 11);
        chk("t3_write", 32'(cmd_write), 32'h1);
        send_bytes(32'hFFFFFFFF, 4, r);
        expect_scan(r, 32'hFFFFFFFF);
        wait_until(r + 2);
`ifndef TM1638_KEY_DEBOUNCE_EN
        chk("t3_keys", 32'(keys), 32'hFFFFFF);
`endif

        // Three bytes only: timeout 64 cycles after the write, then the held scan runs.
        w = next_wrap(cyc);
        scan(32'h00070707, 3, r);
        exp_err = w + 66;
        wait_until(w + 66);
        chk("t4_err", 32'(rx_error), 32'h1);
`ifndef TM1638_KEY_DEBOUNCE_EN
        chk("t4_keys_kept", 32'(keys), 32'hFFFFFF);
`endif
        enable    = 1'b1;
        exp_write = w + 68;
        tick();
        enable = 1'b0;
        wait_until(w + 68);
        chk("t4_next_write", 32'(cmd_write), 32'h1);
        send_bytes(32'h0, 4, r);
        expect_scan(r, 32'h0);
        wait_until(r + 2);
`ifndef TM1638_KEY_DEBOUNCE_EN
        chk("t4_keys", 32'(keys), 32'h0);
        chk("t4_changed", 32'(keys_changed), 32'h1);
`endif

        // Map sequence A,A,B,B,B.
        for (int i = 0; i < 5; i++) begin
            scan((i < 2) ? 32'h00000001 : 32'h40000000, 4, r);
            wait_until(r + 2);
        end
        chk("t5_keys", 32'(keys), 32'h000080);
        chk("t5_valid", 32'(keys_valid), 32'h1);
`ifdef TM1638_KEY_DEBOUNCE_EN
        chk("t5_changed", 32'(keys_changed), 32'h1);
`endif

        // Reset in the middle of reception, then a stray byte in IDLE.
        scan(32'h00000101, 2, r);
        rst       = 1'b1;
        exp_write = NONE;
        exp_valid = NONE;
        exp_err   = NONE;
        run_map   = '0;
        run_len   = 0;
        last_pub  = '0;
        tick();
        tick();
        rst     = 1'b0;
        exp_err = 0;
        send_bytes(32'h55, 1, r);
        chk("t6_err", 32'(rx_error), 32'h1);
        chk("t6_keys", 32'(keys), 32'h0);
        chk("t6_data", 32'(cmd_data), 32'h0);
        wait_until(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
